// File: rtl/ps2_key_event_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 Set-2 key event tracker:
//     - ps2State_t   : tracker FSM states
//     - PS2_BREAK / PS2_EXT / PS2_PAUSE / PS2_CAPS : well-known Set-2 bytes
//     - STATUS_BYTES : controller/keyboard status bytes that are never keys
//     - is_status()  : true for any byte in STATUS_BYTES
//     - is_letter()  : true for the 26 Set-2 make codes of the letters A..Z
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    PAUSE
  } ps2State_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_CAPS  = 8'h58;

  // Error, BAT-passed, echo, ACK, BAT-failed, resend and overrun bytes.
  localparam logic [7:0] STATUS_BYTES [8] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  function automatic logic is_status(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (b == STATUS_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_letter(input logic [7:0] b);
    logic hit;
    case (b)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_event_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_event_tracker
//   Sits between the PS/2 byte receiver and the scancode-to-ASCII ROM.
//   Consumes the raw Set-2 byte stream, tracks left/right shift, drops break
//   codes, E0-extended keys, the E1 Pause sequence and status bytes, and
//   emits one registered {scancode, shift_pressed} pair with a one-cycle
//   key_strobe for every printable-candidate key press.
//
// Parameters
//   LSHIFT_CODE  left shift make code  (default 8'h12)
//   RSHIFT_CODE  right shift make code (default 8'h59)
//   PAUSE_SKIP   bytes discarded after E1 (default 7, must be >= 1)
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset (wins over rx_valid)
//   rx_data[7:0]   in   byte from the PS/2 receiver
//   rx_valid       in   one-cycle pulse, rx_data valid
//   scancode[7:0]  out  last emitted make code, held between strobes
//   shift_pressed  out  shift state captured with scancode, held
//   key_strobe     out  one-cycle pulse, scancode/shift_pressed just updated
//   shift_live     out  current OR of the left/right shift registers
//   busy           out  high while the FSM is mid-prefix (not IDLE)
//   caps_lock      out  caps lock state (only with PS2_CAPS_LOCK_EN)
//
// Configuration
//   PS2_CAPS_LOCK_EN : when defined, 8'h58 toggles an internal caps lock
//                      instead of strobing, and caps lock inverts the shift
//                      flag reported with letter keys.
// ---------------------------------------------------------------------------
module ps2_key_event_tracker
  import ps2_pkg::*;
#(
  parameter logic [7:0] LSHIFT_CODE = 8'h12,
  parameter logic [7:0] RSHIFT_CODE = 8'h59,
  parameter int         PAUSE_SKIP  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] scancode,
  output logic       shift_pressed,
  output logic       key_strobe,
  output logic       shift_live,
`ifdef PS2_CAPS_LOCK_EN
  output logic       busy,
  output logic       caps_lock
`else
  output logic       busy
`endif
);

  localparam int CW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  ps2State_t     state, stateNext;
  logic          lshift, lshiftNext;
  logic          rshift, rshiftNext;
  logic [CW-1:0] skipCount, skipCountNext;
  logic [7:0]    scancodeNext;
  logic          shiftPressedNext;
  logic          keyStrobeNext;
  logic          shiftNow;

  assign shiftNow = lshift | rshift;

`ifdef PS2_CAPS_LOCK_EN
  logic capsLock, capsLockNext;
  assign caps_lock = capsLock;
`endif

  // All state and every registered output live here; the synchronous reset
  // overrides whatever byte arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lshift        <= 1'b0;
      rshift        <= 1'b0;
      skipCount     <= '0;
      scancode      <= 8'h00;
      shift_pressed <= 1'b0;
      key_strobe    <= 1'b0;
`ifdef PS2_CAPS_LOCK_EN
      capsLock      <= 1'b0;
`endif
    end else begin
      state         <= stateNext;
      lshift        <= lshiftNext;
      rshift        <= rshiftNext;
      skipCount     <= skipCountNext;
      scancode      <= scancodeNext;
      shift_pressed <= shiftPressedNext;
      key_strobe    <= keyStrobeNext;
`ifdef PS2_CAPS_LOCK_EN
      capsLock      <= capsLockNext;
`endif
    end
  end

  // Byte interpreter. Everything holds by default; only a valid byte can move
  // the FSM. The shift flag captured with a key uses the shift state from
  // before that byte, which is simply the current register value.
  always_comb begin
    stateNext        = state;
    lshiftNext       = lshift;
    rshiftNext       = rshift;
    skipCountNext    = skipCount;
    scancodeNext     = scancode;
    shiftPressedNext = shift_pressed;
    keyStrobeNext    = 1'b0;
`ifdef PS2_CAPS_LOCK_EN
    capsLockNext     = capsLock;
`endif

    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_data == PS2_BREAK) begin
            stateNext = BRK;
          end else if (rx_data == PS2_EXT) begin
            stateNext = EXT;
          end else if (rx_data == PS2_PAUSE) begin
            stateNext     = PAUSE;
            skipCountNext = CW'(PAUSE_SKIP);
          end else if (is_status(rx_data)) begin
            stateNext = IDLE;
          end else if (rx_data == LSHIFT_CODE) begin
            lshiftNext = 1'b1;
          end else if (rx_data == RSHIFT_CODE) begin
            rshiftNext = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
          end else if (rx_data == PS2_CAPS) begin
            capsLockNext = ~capsLock;
`endif
          end else begin
            scancodeNext  = rx_data;
            keyStrobeNext = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
            shiftPressedNext = shiftNow ^ (capsLock & is_letter(rx_data));
`else
            shiftPressedNext = shiftNow;
`endif
          end
        end

        // A stuttered F0 keeps waiting for the released key's code.
        BRK: begin
          if (rx_data != PS2_BREAK) begin
            if (rx_data == LSHIFT_CODE) lshiftNext = 1'b0;
            if (rx_data == RSHIFT_CODE) rshiftNext = 1'b0;
            stateNext = IDLE;
          end
        end

        // Extended keys (including the fake E0 12 shift) are never reported.
        EXT: begin
          stateNext = (rx_data == PS2_BREAK) ? EXT_BRK : IDLE;
        end

        EXT_BRK: begin
          stateNext = IDLE;
        end

        PAUSE: begin
          skipCountNext = skipCount - CW'(1);
          if (skipCount == CW'(1)) stateNext = IDLE;
        end

        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign shift_live = shiftNow;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_tracker
//   Self-checking bench for ps2_key_event_tracker. Each key byte that should
//   produce a strobe pushes its expected {scancode, shift} onto a queue; a
//   monitor pops and compares whenever key_strobe is seen. Shift/busy levels
//   and reset values are checked directly at chosen points.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_tracker;
  import ps2_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] scancode;
  logic       shift_pressed;
  logic       key_strobe;
  logic       shift_live;
  logic       busy;
`ifdef PS2_CAPS_LOCK_EN
  logic       caps_lock;
`endif

  int checkCount = 0;
  int failCount  = 0;

  typedef struct packed {
    logic [7:0] code;
    logic       shift;
  } expKey_t;

  expKey_t expQueue[$];

  ps2_key_event_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .scancode     (scancode),
    .shift_pressed(shift_pressed),
    .key_strobe   (key_strobe),
    .shift_live   (shift_live),
`ifdef PS2_CAPS_LOCK_EN
    .busy         (busy),
    .caps_lock    (caps_lock)
`else
    .busy         (busy)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest outstanding key.
  always @(negedge clk) begin
    if (key_strobe === 1'b1) begin
      if (expQueue.size() > 0) begin
        expKey_t e;
        e = expQueue.pop_front();
        checkOutput("strobeScancode", 32'(scancode), 32'(e.code));
        checkOutput("strobeShift", 32'(shift_pressed), 32'(e.shift));
      end else begin
        checkOutput("unexpectedStrobe", 32'(scancode), 32'hFFFF_FFFF);
      end
    end
  end

  // Drives one byte for one cycle, returning at the negedge after capture so
  // level outputs can be checked immediately.
  task automatic applyStimulus(input logic [7:0] b, input bit strobes,
                               input bit expShift);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (strobes) expQueue.push_back('{code: b, shift: expShift});
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Convenience for bytes that must never strobe.
  task automatic sendSilent(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idleCycles(3);
    checkOutput("resetScancode", 32'(scancode), 32'h00);
    checkOutput("resetStrobe", 32'(key_strobe), 32'h0);
    checkOutput("resetShiftLive", 32'(shift_live), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Plain key press, then outputs hold.
    applyStimulus(8'h1C, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("holdScancode", 32'(scancode), 32'h1C);
    checkOutput("holdStrobeLow", 32'(key_strobe), 32'h0);

    // Shifted key then release sequence.
    sendSilent(8'h12);
    checkOutput("lshiftLive", 32'(shift_live), 32'h1);
    applyStimulus(8'h1C, 1'b1, 1'b1);
    sendSilent(8'hF0);
    checkOutput("brkBusy", 32'(busy), 32'h1);
    sendSilent(8'h1C);
    checkOutput("brkDone", 32'(busy), 32'h0);
    checkOutput("shiftKeptAfterBreak", 32'(shift_live), 32'h1);
    sendSilent(8'hF0);
    sendSilent(8'h12);
    checkOutput("lshiftReleased", 32'(shift_live), 32'h0);
    applyStimulus(8'h1C, 1'b1, 1'b0);

    // Both shifts, release one, still shifted.
    sendSilent(8'h12);
    sendSilent(8'h59);
    sendSilent(8'hF0);
    sendSilent(8'h12);
    checkOutput("rshiftStillHeld", 32'(shift_live), 32'h1);
    applyStimulus(8'h1C, 1'b1, 1'b1);
    sendSilent(8'hF0);
    sendSilent(8'hF0);
    sendSilent(8'h59);
    checkOutput("bothReleased", 32'(shift_live), 32'h0);
    applyStimulus(8'h1C, 1'b1, 1'b0);

    // Extended keys including fake shift never strobe or shift.
    sendSilent(8'hE0);
    checkOutput("extBusy", 32'(busy), 32'h1);
    sendSilent(8'h12);
    checkOutput("extDone", 32'(busy), 32'h0);
    checkOutput("fakeShiftIgnored", 32'(shift_live), 32'h0);
    sendSilent(8'hE0);
    sendSilent(8'h7C);
    sendSilent(8'hE0);
    sendSilent(8'hF0);
    checkOutput("extBrkBusy", 32'(busy), 32'h1);
    sendSilent(8'h7C);
    sendSilent(8'hE0);
    sendSilent(8'hF0);
    sendSilent(8'h12);
    checkOutput("extBrkDone", 32'(busy), 32'h0);
    applyStimulus(8'h16, 1'b1, 1'b0);

    // Pause sequence: E1 plus seven discarded bytes.
    sendSilent(8'hE1);
    sendSilent(8'h14);
    sendSilent(8'h77);
    sendSilent(8'hE1);
    sendSilent(8'hF0);
    sendSilent(8'h14);
    sendSilent(8'hF0);
    checkOutput("pauseStillBusy", 32'(busy), 32'h1);
    sendSilent(8'h77);
    checkOutput("pauseDone", 32'(busy), 32'h0);
    checkOutput("pauseNoShift", 32'(shift_live), 32'h0);
    applyStimulus(8'h29, 1'b1, 1'b0);

    // Status bytes are dropped.
    sendSilent(8'hFA);
    sendSilent(8'hAA);
    sendSilent(8'hEE);
    sendSilent(8'h00);
    checkOutput("statusKeepsScancode", 32'(scancode), 32'h29);

    // Typematic repeats on back-to-back cycles each strobe.
    @(negedge clk);
    rx_data  = 8'h2B;
    rx_valid = 1'b1;
    expQueue.push_back('{code: 8'h2B, shift: 1'b0});
    @(negedge clk);
    expQueue.push_back('{code: 8'h2B, shift: 1'b0});
    @(negedge clk);
    expQueue.push_back('{code: 8'h2B, shift: 1'b0});
    @(negedge clk);
    rx_valid = 1'b0;

    // Caps lock key: toggles when enabled, plain key otherwise.
`ifdef PS2_CAPS_LOCK_EN
    sendSilent(PS2_CAPS);
    checkOutput("capsOn", 32'(caps_lock), 32'h1);
    applyStimulus(8'h1C, 1'b1, 1'b1);
    applyStimulus(8'h16, 1'b1, 1'b0);
    sendSilent(PS2_CAPS);
    checkOutput("capsOff", 32'(caps_lock), 32'h0);
`else
    applyStimulus(PS2_CAPS, 1'b1, 1'b0);
`endif

    // Build up state, then reset together with a valid byte.
    sendSilent(8'h12);
    applyStimulus(8'h1C, 1'b1, 1'b1);
    sendSilent(8'hE0);
    @(negedge clk);
    reset    = 1'b1;
    rx_data  = 8'h1C;
    rx_valid = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    checkOutput("rstScancode", 32'(scancode), 32'h00);
    checkOutput("rstShiftPressed", 32'(shift_pressed), 32'h0);
    checkOutput("rstStrobe", 32'(key_strobe), 32'h0);
    checkOutput("rstShiftLive", 32'(shift_live), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    applyStimulus(8'h1C, 1'b1, 1'b0);

    idleCycles(4);
    checkOutput("pendingStrobes", 32'(expQueue.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
